// File: rtl/score_pkg.sv
// score_pkg: shared score RAM widths, constants and recorder state encoding
package score_pkg;
    localparam int NOTE_W         = 4;
    localparam int ADDR_W         = 7;
    localparam int TEMPO_W        = 26;
    localparam int SCORE_DEPTH    = 2 ** ADDR_W;
    localparam int COUNT_IN_BEATS = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_DONE   = 2'd2
`ifdef SCORE_RECORDER_COUNT_IN_EN
        , S_COUNT_IN = 2'd3
`endif
    } rec_state_t;
endpackage

// File: rtl/score_recorder_if.sv
// score_recorder_if: score RAM write port (wr_en strobe, wr_addr, wr_data); master drives, slave receives
interface score_recorder_if;
    import score_pkg::*;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [NOTE_W-1:0] wr_data;
    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/beat_timer.sv
// beat_timer: free-running beat counter with a period latched on clr (0 treated as 1)
// Ports: clk, reset_n (async active-low), clr (sync clear + period load), run (count enable),
// period (beat period in clk cycles), tick (high in the last cycle of each period)
module beat_timer
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               run,
    input  logic [TEMPO_W-1:0] period,
    output logic               tick
);
    logic [TEMPO_W-1:0] period_q, cnt;
    assign tick = run && cnt == period_q - TEMPO_W'(1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
            cnt      <= '0;
        end else if (clr) begin
            period_q <= (period == '0) ? TEMPO_W'(1) : period;
            cnt      <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + TEMPO_W'(1);
        end
    end
endmodule

// File: rtl/score_recorder.sv
// score_recorder: quantises detected notes to one code per beat and writes them into the score RAM
// Ports: clk, reset_n (async active-low); start/stop take control pulses; tempo beat period;
// note_in/note_valid pitch-detect input; wr score RAM write port (master);
// beat, recording, done, length status.
// Optional: define SCORE_RECORDER_COUNT_IN_EN for COUNT_IN_BEATS lead-in beats before recording.
module score_recorder
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic [NOTE_W-1:0]  note_in,
    input  logic               note_valid,
    score_recorder_if.master   wr,
    output logic               beat,
    output logic               recording,
    output logic               done,
    output logic [ADDR_W:0]    length
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCORE_DEPTH - 1);
    rec_state_t state, state_nx;
    logic tick, go, run, closing, rec_beat, wr_q, stop_q;
    logic [ADDR_W-1:0] addr;
    logic [NOTE_W-1:0] cap, data_q, sample;
`ifdef SCORE_RECORDER_COUNT_IN_EN
    localparam rec_state_t START_STATE = S_COUNT_IN;
    localparam int CI_W = $clog2(COUNT_IN_BEATS);
    logic [CI_W-1:0] ci_cnt;
    logic ci_last;
    assign run     = state == S_RECORD || state == S_COUNT_IN;
    assign ci_last = tick && ci_cnt == CI_W'(COUNT_IN_BEATS - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ci_cnt <= '0;
        else ci_cnt <= go ? '0 : (state == S_COUNT_IN && tick) ? ci_cnt + CI_W'(1) : ci_cnt;
    end
`else
    localparam rec_state_t START_STATE = S_RECORD;
    assign run = state == S_RECORD;
`endif
    assign go = start && !stop && (state == S_IDLE || state == S_DONE);
    // The take's final write is on the bus: a coinciding beat must not start another write
    assign closing   = wr_q && (addr == LAST_ADDR || stop_q);
    assign beat      = tick && !closing;
    assign rec_beat  = beat && state == S_RECORD;
    // A valid sample on the boundary cycle itself wins over the held capture
    assign sample    = note_valid ? note_in : cap;
    assign recording = state == S_RECORD;
    assign done      = state == S_DONE;
    assign wr.wr_en   = wr_q;
    assign wr.wr_addr = addr;
    assign wr.wr_data = data_q;

    beat_timer u_beat_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (go),
        .run    (run),
        .period (tempo),
        .tick   (tick)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = go ? START_STATE : state;
`ifdef SCORE_RECORDER_COUNT_IN_EN
            S_COUNT_IN:     state_nx = stop ? S_DONE : ci_last ? S_RECORD : S_COUNT_IN;
`endif
            // stop on a boundary lingers one cycle so that beat's write still goes out
            S_RECORD:       state_nx = (closing || (stop && !rec_beat)) ? S_DONE : S_RECORD;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            wr_q   <= 1'b0;
            stop_q <= 1'b0;
            data_q <= NOTE_REST;
            cap    <= NOTE_REST;
            addr   <= '0;
            length <= '0;
        end else begin
            state  <= state_nx;
            wr_q   <= rec_beat;
            stop_q <= stop && rec_beat;
            data_q <= rec_beat ? sample : NOTE_REST;
            cap    <= (go || rec_beat) ? NOTE_REST : (recording && note_valid) ? note_in : cap;
            addr   <= go ? '0 : addr + ADDR_W'(wr_q);
            length <= go ? '0 : length + (ADDR_W + 1)'(wr_q);
        end
    end
endmodule

// File: tb/tb_score_recorder.sv
// tb_score_recorder: directed and randomized takes checked against a per-beat arithmetic model
module tb_score_recorder;
    import score_pkg::*;
`ifdef SCORE_RECORDER_COUNT_IN_EN
    localparam int CI = COUNT_IN_BEATS;
`else
    localparam int CI = 0;
`endif
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [TEMPO_W-1:0] tempo = '0;
    logic [NOTE_W-1:0]  note_in = '0;
    logic               note_valid = 1'b0;
    logic               beat, recording, done;
    logic [ADDR_W:0]    length;
    int passed = 0;
    int fails = 0;
    int total = 0;
    int cur_j = -1;
    int last_len = 0;
    logic              vv [0:1023];
    logic [NOTE_W-1:0] dd [0:1023];

    score_recorder_if wr();

    score_recorder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .tempo     (tempo),
        .note_in   (note_in),
        .note_valid(note_valid),
        .wr        (wr),
        .beat      (beat),
        .recording (recording),
        .done      (done),
        .length    (length)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s at j=%0d: observed %0d expected %0d", tag, cur_j, obs, exp);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 1024; i++) begin
            vv[i] = 1'($urandom_range(0, 1));
            dd[i] = NOTE_W'($urandom);
        end
    endtask

    task automatic fill_const(input logic [NOTE_W-1:0] n);
        for (int i = 0; i < 1024; i++) begin
            vv[i] = 1'b1;
            dd[i] = n;
        end
    endtask

    // One take: offsets j count cycles from the first cycle after the start pulse.
    // Beat k of the recording covers offsets p+k*t .. p+(k+1)*t-1 and is written at p+(k+1)*t.
    task automatic run_take(input int tq, input int stop_at, input int start_at);
        int t, p, nw, d, jj, bnd, lexp;
        bit we;
        logic [NOTE_W-1:0] ed [0:127];
        t = (tq == 0) ? 1 : tq;
        p = CI * t;
        for (int k = 0; k < SCORE_DEPTH; k++) begin
            ed[k] = NOTE_REST;
            for (int i = p + k * t; i < p + (k + 1) * t; i++)
                if (vv[i]) ed[k] = dd[i];
        end
        if (stop_at < 0) begin
            nw = SCORE_DEPTH;
            d  = p + SCORE_DEPTH * t + 1;
        end else begin
            bnd = (stop_at + 1) / t;
            nw  = (bnd > CI) ? bnd - CI : 0;
            d   = ((stop_at + 1) % t == 0 && bnd > CI) ? stop_at + 2 : stop_at + 1;
        end
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b0; note_valid = 1'b0; tempo = TEMPO_W'(tq);
        @(posedge clk); #1;
        start = 1'b0; tempo = TEMPO_W'($urandom);
        for (int j = 0; j <= d + 3; j++) begin
            cur_j = j;
            note_valid = vv[j];
            note_in    = dd[j];
            stop       = (j == stop_at);
            start      = (j == start_at);
            @(negedge clk);
            jj = j - p;
            we = jj > 0 && jj % t == 0 && jj / t <= nw;
            lexp = (jj < 1) ? 0 : ((jj - 1) / t < nw) ? (jj - 1) / t : nw;
            chk("beat", 32'(beat), 32'(((j + 1) % t == 0) && j < d && !(we && j == d - 1)));
            chk("wr_en", 32'(wr.wr_en), 32'(we));
            if (we) begin
                chk("wr_addr", 32'(wr.wr_addr), 32'(jj / t - 1));
                chk("wr_data", 32'(wr.wr_data), 32'(ed[jj / t - 1]));
            end
            chk("recording", 32'(recording), 32'(j >= p && j < d));
            chk("done", 32'(done), 32'(j >= d));
            chk("length", 32'(length), 32'(lexp));
            @(posedge clk); #1;
        end
        stop = 1'b0;
        start = 1'b0;
        note_valid = 1'b0;
        last_len = nw;
    endtask

    initial begin
        int t, te, s;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", 32'(wr.wr_en), 0);
        chk("rst_wr_addr", 32'(wr.wr_addr), 0);
        chk("rst_wr_data", 32'(wr.wr_data), 0);
        chk("rst_beat", 32'(beat), 0);
        chk("rst_recording", 32'(recording), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_length", 32'(length), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_recording", 32'(recording), 0);
        chk("idle_done", 32'(done), 0);

        // basic quantisation: (0,5), (1,rest), (2,3 from the boundary cycle)
        fill_rand();
        for (int i = CI * 4; i < CI * 4 + 12; i++) vv[i] = 1'b0;
        vv[CI * 4 + 1] = 1'b1; dd[CI * 4 + 1] = 4'd5;
        vv[CI * 4 + 9] = 1'b1; dd[CI * 4 + 9] = 4'd9;
        vv[CI * 4 + 11] = 1'b1; dd[CI * 4 + 11] = 4'd3;
        run_take(4, CI * 4 + 12, -1);

        // tempo 0 behaves as 1; stop lands on a boundary
        fill_const(4'd7);
        run_take(0, CI + 9, -1);

        // stop one cycle before a boundary, plus a start that must be ignored
        fill_rand();
        run_take(5, CI * 5 + 8, CI * 5 + 3);

        // stop on a boundary
        fill_rand();
        run_take(3, CI * 3 + 8, 1);

        // start and stop together in DONE: stop wins
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("ss_done", 32'(done), 1);
        chk("ss_recording", 32'(recording), 0);
        chk("ss_length", 32'(length), 32'(last_len));

        // full wrap
        fill_const(4'd1);
        run_take(2, -1, -1);

        for (int r = 0; r < 6; r++) begin
            t  = $urandom_range(0, 6);
            te = (t == 0) ? 1 : t;
            s  = CI * te + $urandom_range(0, 20 * te);
            fill_rand();
            run_take(t, s, (s > 0) ? $urandom_range(0, s - 1) : -1);
        end

        // reset mid-take
        @(posedge clk); #1;
        tempo = 26'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; note_valid = 1'b1; note_in = 4'd6;
        repeat (CI * 3 + 7) @(posedge clk);
        #1;
        chk("pre_reset_length", 32'(length), 2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_wr_en", 32'(wr.wr_en), 0);
        chk("ar_wr_addr", 32'(wr.wr_addr), 0);
        chk("ar_wr_data", 32'(wr.wr_data), 0);
        chk("ar_beat", 32'(beat), 0);
        chk("ar_recording", 32'(recording), 0);
        chk("ar_done", 32'(done), 0);
        chk("ar_length", 32'(length), 0);
        @(posedge clk); #1;
        reset_n = 1'b1; note_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_recording", 32'(recording), 0);
        chk("post_reset_done", 32'(done), 0);
        chk("post_reset_wr_en", 32'(wr.wr_en), 0);

        fill_rand();
        run_take(2, CI * 2 + 9, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/score_recorder.md
Name: score_recorder

Overview:
- Writer-side counterpart to the score loader. It captures the player's detected recorder notes, quantised to one 4-bit note code per tempo beat, and writes them sequentially into a dual-port score RAM.
- The RAM uses the same 7-bit address / 4-bit note format that the loader reads, so a recorded take can be replayed through the normal display path.
- It sits between the pitch-detect front end and the score RAM write port, and is controlled from the game FSM via start/stop.

Parameters:
- NOTE_W, 4, width of a note code; code 0 = rest.
- ADDR_W, 7, score RAM address width; depth = 2**ADDR_W = 128 notes.
- TEMPO_W, 26, width of the beat-period count in clk cycles.
- COUNT_IN_BEATS, 4, number of lead-in beats. Used only when COUNT_IN_EN is defined.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new take.
- stop  in  1  one-cycle pulse; ends the take early.
- tempo  in  TEMPO_W  beat period in clk cycles; latched at start.
- note_in  in  NOTE_W  detected note code.
- note_valid  in  1  note_in is meaningful this cycle.
- wr_en  out  1  score RAM write strobe.
- wr_addr  out  ADDR_W  score RAM write address.
- wr_data  out  NOTE_W  score RAM write data.
- beat  out  1  one-cycle pulse at each beat boundary, including count-in beats.
- recording  out  1  high in the RECORD state.
- done  out  1  high in the DONE state.
- length  out  ADDR_W+1  number of notes written in the current take, 0..128.

Behaviour:
- Clock and reset:
  - Single clock: clk. Reset is asynchronous, active-low: reset_n.
  - While reset_n=0, all outputs are 0, the state is IDLE, and all counters and latches are 0.
- States: IDLE, COUNT_IN (exists only with COUNT_IN_EN), RECORD, DONE.
- IDLE:
  - On start, latch tempo into tempo_q. A tempo value of 0 is treated as 1.
  - Clear length, the address counter, the beat counter and the capture register.
  - Go to RECORD, or to COUNT_IN when that feature is compiled in.
- Beat timer:
  - beat_cnt counts 0..tempo_q-1 and wraps. It runs in COUNT_IN and RECORD.
  - beat pulses in the cycle where beat_cnt==tempo_q-1, giving a period of exactly tempo_q cycles.
  - The first beat occurs tempo_q cycles after the state entry cycle.
- Capture:
  - During each beat interval, cap holds the last note_in seen with note_valid=1, including the boundary cycle itself.
  - If no valid sample occurs in the interval, cap = 0 (rest).
  - cap is reset to 0 after each boundary.
- Write:
  - In the cycle after a RECORD beat, wr_en=1 for exactly one cycle, wr_data = captured note, wr_addr = current address.
  - The address then increments and length increments in that same cycle.
  - Write latency from the beat boundary is 1 cycle.
- Full:
  - After the write to address 127, length=128 and the address wraps to 0.
  - The state goes to DONE in the cycle following that write. No further writes occur.
- stop:
  - stop in RECORD or COUNT_IN goes to DONE on the next cycle, and the partial beat is discarded.
  - If stop coincides with a beat boundary, the write for that beat is still performed, and DONE is entered after it.
- start/stop priority:
  - start while in RECORD or COUNT_IN is ignored.
  - start and stop in the same cycle: stop wins.
  - start in DONE begins a new take, identical to start in IDLE.
- DONE: done=1, recording=0, length holds. tempo is ignored outside IDLE and DONE.
- reset_n deasserted mid-take: return to IDLE immediately. Any write not yet issued is lost; already-written RAM contents are unaffected.

Optional Feature:
- Macro: SCORE_RECORDER_COUNT_IN_EN.
- When defined:
  - start enters COUNT_IN. beat pulses for COUNT_IN_BEATS beats but nothing is captured or written, and recording=0.
  - After the last count-in beat, the state moves to RECORD and the beat counter continues seamlessly, so the period is unchanged.
- When undefined: the COUNT_IN state and its counter are absent, and start goes straight to RECORD.

Decomposition:
- Shared package score_pkg holds:
  - Constants: NOTE_W, ADDR_W, TEMPO_W, NOTE_REST=0, SCORE_DEPTH=128.
  - The recorder state encoding.
- The loader reuses the same width constants.
- One sub-module, beat_timer: latched period, wraps, pulses beat, and has a synchronous clear.

Test Plan:
- Basic quantisation:
  - Stimulus: tempo=4, start. Beat 0 note 5 valid; beat 1 nothing valid; beat 2 note 9 then note 3 on the boundary cycle.
  - Response: writes (addr, data) = (0,5), (1,0), (2,3), each 1 cycle after the beat pulse; length=3.
- Tempo edge:
  - Stimulus: tempo=0, start.
  - Response: beat every cycle; note 7 held valid produces 7 written at consecutive addresses.
- Full wrap:
  - Stimulus: tempo=2, note 1 held valid.
  - Response: exactly 128 writes at addresses 0..127; done=1 the cycle after the last write; length=128; wr_en stays 0 afterwards.
- Stop cases:
  - Stimulus: stop 1 cycle before a boundary. Response: no write for that beat, DONE next cycle.
  - Stimulus: stop on a boundary cycle. Response: that beat's write occurs, then DONE.
- Reset and restart:
  - Stimulus: reset_n pulsed low mid-take.
  - Response: all outputs 0 asynchronously, state IDLE.
  - Stimulus: start from DONE. Response: length=0, address restarts at 0.
- Count-in (SCORE_RECORDER_COUNT_IN_EN, tempo=3):
  - Response: 4 beat pulses with no wr_en and recording=0; the first write follows the 5th beat at addr 0.
